// File: rtl/imem_loader.sv
// imem_loader
// Program loader for the MIPS core's instruction memory. A framed byte
// stream (LEN, LEN words of IW/8 bytes MSB first, checksum) arrives over a
// valid/ready handshake. Each assembled word is written to the instruction
// SRAM with a one-cycle write pulse. The core is held in reset until a
// complete image has passed its 8-bit checksum.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   start      begin a load (honoured only in IDLE, DONE or ERR)
//   byte_i     stream byte
//   byte_valid byte_i is valid
//   byte_ready loader can accept a byte this cycle
//   mem_addr   SRAM write address
//   mem_data   SRAM write data
//   mem_we     SRAM write enable (one-cycle pulse)
//   mem_cs     SRAM chip select (same as mem_we)
//   cpu_hold   drives the core's reset; low only after a good load
//   done       last load succeeded
//   err        last load failed its checksum
module imem_loader #(
    parameter int IW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [AW-1:0] mem_addr,
    output logic [IW-1:0] mem_data,
    output logic          mem_we,
    output logic          mem_cs,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam int NB  = IW / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]     state;
    logic [2:0]     next_state;
    logic [BCW-1:0] byte_cnt;
    logic [AW:0]    word_cnt;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     csum;
    logic [IW-1:0]  word_reg;

    logic           accept;
    logic           last_byte;
    logic [7:0]     csum_add;
    logic [IW-1:0]  word_next;
    logic [AW:0]    len_cnt;
    logic           next_ready;

    assign accept    = byte_valid && byte_ready;
    assign last_byte = (byte_cnt == BCW'(NB - 1));
    assign csum_add  = csum + byte_i;
    assign word_next = (word_reg << 8) | IW'(byte_i);

    // A LEN of zero stands for a full memory image of 2^AW words.
    always_comb begin
        if (byte_i == 8'h00) begin
            len_cnt = {1'b1, {AW{1'b0}}};
        end else begin
            len_cnt = (AW+1)'(byte_i);
        end
    end

    // Next-state decode. byte_ready, mem_we and mem_cs are registered from
    // the next state so they are valid for the whole cycle they apply to.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LEN;
            S_LEN:   if (accept) next_state = S_DATA;
            S_DATA:  if (accept && last_byte) next_state = S_WRITE;
            S_WRITE: next_state = (word_cnt == (AW+1)'(1)) ? S_CHK : S_DATA;
            S_CHK:   if (accept) next_state = (csum_add == 8'h00) ? S_DONE : S_ERR;
            S_DONE:  if (start) next_state = S_LEN;
            S_ERR:   if (start) next_state = S_LEN;
            default: next_state = S_IDLE;
        endcase
        next_ready = (next_state == S_LEN) || (next_state == S_DATA) ||
                     (next_state == S_CHK);
    end

    // Datapath and registered outputs. mem_addr/mem_data are loaded together
    // with the write pulse so they are stable for the whole WRITE cycle and
    // then hold until the next word is complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_cs     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            wr_addr    <= '0;
            csum       <= '0;
            word_reg   <= '0;
        end else begin
            state      <= next_state;
            byte_ready <= next_ready;
            mem_we     <= (next_state == S_WRITE);
            mem_cs     <= (next_state == S_WRITE);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        word_cnt <= len_cnt;
                        wr_addr  <= '0;
                        csum     <= byte_i;
                        byte_cnt <= '0;
                        word_reg <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_reg <= word_next;
                        csum     <= csum_add;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            mem_data <= word_next;
                            mem_addr <= wr_addr;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    wr_addr  <= wr_addr + 1'b1;
                    word_cnt <= word_cnt - 1'b1;
                end
                S_CHK: begin
                    if (accept) begin
                        csum <= csum_add;
                        if (csum_add == 8'h00) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
